// File: rtl/dmem_lsu_master.sv
// dmem_lsu_master: byte-addressed load/store master for word-organised datamemory
module dmem_lsu_master #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_signed,
    input  logic [31:0]           req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_we,
    output logic [DATA_WIDTH-1:0] mem_in,
    input  logic [DATA_WIDTH-1:0] mem_out
);
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] RD_ADDR   = 3'd1;
    localparam logic [2:0] RD_DATA   = 3'd2;
    localparam logic [2:0] RMW_ADDR  = 3'd3;
    localparam logic [2:0] RMW_MERGE = 3'd4;
    localparam logic [2:0] WR        = 3'd5;
    localparam logic [2:0] RESP      = 3'd6;

    logic [2:0]            state;
    logic [1:0]            size_q;
    logic [1:0]            lane_q;
    logic                  sgn_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  req_err;
    logic [7:0]            byte_sel;
    logic [15:0]           half_sel;
    logic [DATA_WIDTH-1:0] load_val;
    logic [DATA_WIDTH-1:0] merged;

    assign req_ready = state == IDLE;
    assign rsp_valid = state == RESP;
    assign mem_we    = state == WR;

    assign req_err = req_size == 2'b11 ||
                     (req_size == 2'b01 && req_addr[0]) ||
                     (req_size == 2'b10 && req_addr[1:0] != 2'b00) ||
                     req_addr[31:ADDR_WIDTH+2] != '0;

    always_comb begin
        byte_sel = mem_out[{lane_q, 3'b000} +: 8];
        half_sel = lane_q[1] ? mem_out[31:16] : mem_out[15:0];
        load_val = size_q == 2'b00 ? {{24{sgn_q & byte_sel[7]}}, byte_sel} :
                   size_q == 2'b01 ? {{16{sgn_q & half_sel[15]}}, half_sel} : mem_out;
        merged = mem_out;
        if (size_q == 2'b00)
            merged[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
        else
            merged[{lane_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end

    // mem_address/mem_in are registered so they hold their last value outside an access
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            size_q      <= '0;
            lane_q      <= '0;
            sgn_q       <= 1'b0;
            wdata_q     <= '0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            mem_address <= '0;
            mem_in      <= '0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    size_q    <= req_size;
                    lane_q    <= req_addr[1:0];
                    sgn_q     <= req_signed;
                    wdata_q   <= req_wdata;
                    rsp_rdata <= '0;
                    rsp_err   <= req_err;
                    if (!req_err) mem_address <= req_addr[ADDR_WIDTH+1:2];
                    if (!req_err && req_we && req_size == 2'b10) mem_in <= req_wdata;
                    state <= req_err ? RESP : !req_we ? RD_ADDR : req_size == 2'b10 ? WR : RMW_ADDR;
                end
                RD_ADDR:   state <= RD_DATA;
                RD_DATA: begin
                    rsp_rdata <= load_val;
                    state     <= RESP;
                end
                RMW_ADDR:  state <= RMW_MERGE;
                RMW_MERGE: begin
                    mem_in <= merged;
                    state  <= WR;
                end
                WR:        state <= RESP;
                default:   state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_lsu_master.sv
// tb_dmem_lsu_master: directed and random load/store checks against a byte-array memory model
module tb_dmem_lsu_master;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [9:0]  mem_address;
    logic        mem_we;
    logic [31:0] mem_in;
    logic [31:0] mem_out = '0;

    logic [31:0] mem [1024];
    logic [7:0]  rm [4096];
    int errors = 0;
    int checks = 0;
    int we_cnt = 0;

    dmem_lsu_master #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .mem_address(mem_address), .mem_we(mem_we),
        .mem_in(mem_in), .mem_out(mem_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) mem[mem_address] <= mem_in;
        mem_out <= mem[mem_address];
    end

    always @(negedge clk) if (mem_we) we_cnt++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic ref_err(input logic [1:0] sz, input logic [31:0] a);
        return sz == 2'b11 || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00) || a >= 32'h1000;
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic sg, input logic [31:0] a);
        logic [31:0] v = '0;
        int n = 1 << sz;
        for (int i = 0; i < n; i++) v |= 32'(rm[int'(a[11:0]) + i]) << (8 * i);
        if (sg && n == 1 && v[7]) v |= 32'hFFFF_FF00;
        if (sg && n == 2 && v[15]) v |= 32'hFFFF_0000;
        return v;
    endfunction

    function automatic logic [31:0] ref_word(input int w);
        return {rm[4*w+3], rm[4*w+2], rm[4*w+1], rm[4*w]};
    endfunction

    task automatic run(input logic we, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd, output logic [31:0] rd);
        logic e = ref_err(sz, a);
        logic [31:0] erd = (we || e) ? 32'h0 : ref_load(sz, sg, a);
        int elat = e ? 1 : !we ? 3 : sz == 2'b10 ? 2 : 4;
        int w0 = we_cnt;
        int lat = 1;
        @(negedge clk);
        chk("ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_we = we; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("ready_busy", 32'(req_ready), 32'd0);
        while (!rsp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        rd = rsp_rdata;
        chk("rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rsp_err", 32'(rsp_err), 32'(e));
        chk("rdata", rd, erd);
        chk("latency", 32'(lat), 32'(elat));
        chk("we_pulses", 32'(we_cnt - w0), (!e && we) ? 32'd1 : 32'd0);
        if (!e && we) for (int i = 0; i < (1 << sz); i++) rm[int'(a[11:0]) + i] = wd[8*i +: 8];
        @(posedge clk); #1;
        chk("rsp_pulse", 32'(rsp_valid), 32'd0);
    endtask

    initial begin
        logic [31:0] rd;
        int w0;
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        for (int i = 0; i < 4096; i++) rm[i] = '0;
        #12;
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_addr", 32'(mem_address), 32'd0);
        chk("rst_in", mem_in, 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        @(negedge clk) rst_n = 1'b1;

        run(1, 2'b10, 0, 32'h0D40, 32'hDEADBEEF, rd);
        chk("sw_addr", 32'(mem_address), 32'h350);
        chk("sw_in", mem_in, 32'hDEADBEEF);
        run(0, 2'b10, 0, 32'h0D40, 0, rd);  chk("lw_dead", rd, 32'hDEADBEEF);
        run(1, 2'b00, 0, 32'h0D41, 32'h12, rd);
        run(0, 2'b10, 0, 32'h0D40, 0, rd);  chk("lw_merge", rd, 32'hDEAD12EF);
        run(0, 2'b00, 1, 32'h0D43, 0, rd);  chk("lb", rd, 32'hFFFFFFDE);
        run(0, 2'b00, 0, 32'h0D43, 0, rd);  chk("lbu", rd, 32'h000000DE);
        run(0, 2'b01, 1, 32'h0D42, 0, rd);  chk("lh", rd, 32'hFFFFDEAD);
        run(0, 2'b10, 0, 32'h0D42, 0, rd);
        run(0, 2'b01, 0, 32'h0003, 0, rd);
        run(1, 2'b11, 0, 32'h0000, 32'h55, rd);
        run(0, 2'b10, 0, 32'h1000, 0, rd);
        run(1, 2'b01, 0, 32'h0D43, 32'h7777, rd);
        for (int i = 0; i < 16; i++) run(1, 2'b10, 0, 32'(i * 4), 32'(i), rd);
        for (int i = 0; i < 16; i++) begin
            run(0, 2'b10, 0, 32'(i * 4), 0, rd);
            chk("loop_lw", rd, 32'(i));
        end

        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_addr = 32'h0D41; req_wdata = 32'hA5;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        w0 = we_cnt;
        rst_n = 1'b0;
        #1;
        chk("abort_we", 32'(mem_we), 32'd0);
        chk("abort_ready", 32'(req_ready), 32'd1);
        chk("abort_addr", 32'(mem_address), 32'd0);
        chk("abort_in", mem_in, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_valid", 32'(rsp_valid), 32'd0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_abort_valid", 32'(rsp_valid), 32'd0);
        end
        chk("abort_pulses", 32'(we_cnt - w0), 32'd0);
        chk("abort_word", mem[10'h350], ref_word(32'h350));
        run(0, 2'b10, 0, 32'h0D40, 0, rd);

        for (int n = 0; n < 250; n++) begin
            int r = $urandom_range(0, 9);
            logic [1:0] sz = r == 9 ? 2'b11 : 2'(r % 3);
            logic [1:0] lane = 2'($urandom_range(0, 3));
            logic [31:0] a;
            if ($urandom_range(0, 7) != 0) lane &= sz == 2'b00 ? 2'b11 : sz == 2'b01 ? 2'b10 : 2'b00;
            a = {24'h0, 4'($urandom_range(0, 15)), 2'b00} | 32'(lane);
            if ($urandom_range(0, 15) == 0) a |= 32'h1000 << $urandom_range(0, 19);
            run(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, rd);
        end
        for (int i = 0; i < 16; i++) chk("final_word", mem[i], ref_word(i));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
